axis_to_fifo: RTL and testbench



---
 rtl/axis_to_fifo.sv | 218 +++++++++++++++++++++
 tb/tb_axis_to_fifo.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_to_fifo.sv
// AXI4-Stream slave that serializes each packet into a first-word-fall-through
// narrow word stream: a header beat carrying TUSER, then every data beat split
// into FIFO_DATA_WIDTH words with per-word strobes. A packet whose final beat
// is full gets an all-zero terminator beat so end of packet stays detectable.
module axis_to_fifo #(
   parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
   parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
   parameter int unsigned FIFO_DATA_WIDTH      = 32
) (
   input  logic                                 axi_aclk,
   input  logic                                 axi_areset,
   input  logic                                 sw_rst,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tstrb,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
   input  logic                                 s_axis_tvalid,
   output logic                                 s_axis_tready,
   input  logic                                 s_axis_tlast,
   input  logic                                 fifo_rd_en,
   output logic [FIFO_DATA_WIDTH-1:0]           fifo_dout,
   output logic [FIFO_DATA_WIDTH/8-1:0]         fifo_dout_strb,
   output logic                                 fifo_empty,
   output logic [31:0]                          pkt_count,
   output logic                                 proto_err
);

   localparam int unsigned DW      = C_S_AXIS_DATA_WIDTH;
   localparam int unsigned UW      = C_S_AXIS_TUSER_WIDTH;
   localparam int unsigned FW      = FIFO_DATA_WIDTH;
   localparam int unsigned WORDS   = DW / FW;
   localparam int unsigned IDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int unsigned STRB_W  = DW / 8;
   localparam int unsigned WSTRB_W = FW / 8;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_DATA,
      S_NEXT,
      S_TERM
   } state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                ready_q, ready_d;
   logic                empty_q, empty_d;
   logic                accept_c, consume_c, pkt_done_c;

   logic [DW-1:0]       tdata_q;
   logic [STRB_W-1:0]   tstrb_q;
   logic                tlast_q;
   logic [UW-1:0]       tuser_q;
   logic [31:0]         pkt_count_q;
   logic                proto_err_q;

   logic [WORDS-1:0][FW-1:0]      data_words;
   logic [WORDS-1:0][FW-1:0]      hdr_words;
   logic [WORDS-1:0][WSTRB_W-1:0] strb_words;
   logic [FW-1:0]                 word_c;
   logic [WSTRB_W-1:0]            wstrb_c;

   assign data_words = tdata_q;
   assign hdr_words  = DW'(tuser_q);
   assign strb_words = tstrb_q;

   assign s_axis_tready  = ready_q;
   assign fifo_empty     = empty_q;
   assign fifo_dout      = word_c;
   assign fifo_dout_strb = wstrb_c;
   assign pkt_count      = pkt_count_q;
   assign proto_err      = proto_err_q;

   // State, word index and handshake flags
   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         ready_q <= 1'b0;
         empty_q <= 1'b1;
      end else if (sw_rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         ready_q <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ready_q <= ready_d;
         empty_q <= empty_d;
      end
   end

   // Next-state logic: accept a beat, then walk idx across its words
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      accept_c   = 1'b0;
      pkt_done_c = 1'b0;
      consume_c  = fifo_rd_en && !empty_q;
      case (state_q)
         S_IDLE: begin
            if (s_axis_tvalid && ready_q) begin
               accept_c = 1'b1;
               idx_d    = '0;
               state_d  = S_HDR;
            end
         end
         S_HDR: begin
            if (consume_c) begin
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  state_d = S_DATA;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         S_DATA: begin
            if (consume_c) begin
               if (idx_q == IDX_LAST) begin
                  idx_d = '0;
                  if (!tlast_q) begin
                     state_d = S_NEXT;
                  end else if (&tstrb_q) begin
                     state_d = S_TERM;
                  end else begin
                     state_d    = S_IDLE;
                     pkt_done_c = 1'b1;
                  end
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         S_NEXT: begin
            if (s_axis_tvalid && ready_q) begin
               accept_c = 1'b1;
               idx_d    = '0;
               state_d  = S_DATA;
            end
         end
         S_TERM: begin
            if (consume_c) begin
               if (idx_q == IDX_LAST) begin
                  idx_d      = '0;
                  state_d    = S_IDLE;
                  pkt_done_c = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
         end
      endcase
      ready_d = (state_d == S_IDLE) || (state_d == S_NEXT);
      empty_d = ready_d;
   end

   // Beat/header capture, packet counter and sticky protocol error
   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         tdata_q     <= '0;
         tstrb_q     <= '0;
         tlast_q     <= 1'b0;
         tuser_q     <= '0;
         pkt_count_q <= '0;
         proto_err_q <= 1'b0;
      end else if (sw_rst) begin
         tdata_q     <= '0;
         tstrb_q     <= '0;
         tlast_q     <= 1'b0;
         tuser_q     <= '0;
         pkt_count_q <= '0;
         proto_err_q <= 1'b0;
      end else begin
         if (accept_c) begin
            tdata_q <= s_axis_tdata;
            tstrb_q <= s_axis_tstrb;
            tlast_q <= s_axis_tlast;
            if (state_q == S_IDLE) begin
               tuser_q <= s_axis_tuser;
            end
            // A partial non-last beat would look like end of packet downstream
            if (!s_axis_tlast && !(&s_axis_tstrb)) begin
               proto_err_q <= 1'b1;
            end
         end
         if (pkt_done_c) begin
            pkt_count_q <= pkt_count_q + 32'd1;
         end
      end
   end

   // Current word selection from registered state (zero when nothing pending)
   always_comb begin
      word_c  = '0;
      wstrb_c = '0;
      case (state_q)
         S_HDR: begin
            word_c  = hdr_words[idx_q];
            wstrb_c = '1;
         end
         S_DATA: begin
            word_c  = data_words[idx_q];
            wstrb_c = strb_words[idx_q];
         end
         default: begin
            word_c  = '0;
            wstrb_c = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_axis_to_fifo.sv
// Directed bench for axis_to_fifo: header/data/terminator word sequences,
// backpressure on both sides, protocol error and reset behaviour.
module tb_axis_to_fifo;

   localparam int unsigned DW    = 256;
   localparam int unsigned UW    = 128;
   localparam int unsigned FW    = 32;
   localparam int unsigned WORDS = DW / FW;
   localparam int unsigned IW    = $clog2(WORDS);
   localparam int unsigned SW    = DW / 8;
   localparam int unsigned FSW   = FW / 8;

   typedef struct packed {
      logic [FW-1:0]  d;
      logic [FSW-1:0] s;
   } word_t;

   logic            axi_aclk = 1'b0;
   logic            axi_areset;
   logic            sw_rst;
   logic [DW-1:0]   s_axis_tdata;
   logic [SW-1:0]   s_axis_tstrb;
   logic [UW-1:0]   s_axis_tuser;
   logic            s_axis_tvalid;
   logic            s_axis_tready;
   logic            s_axis_tlast;
   logic            fifo_rd_en;
   logic [FW-1:0]   fifo_dout;
   logic [FSW-1:0]  fifo_dout_strb;
   logic            fifo_empty;
   logic [31:0]     pkt_count;
   logic            proto_err;

   word_t exp_q[$];
   int    n_tests = 0;
   int    n_fail  = 0;

   axis_to_fifo #(
      .C_S_AXIS_DATA_WIDTH (DW),
      .C_S_AXIS_TUSER_WIDTH(UW),
      .FIFO_DATA_WIDTH     (FW)
   ) dut (
      .axi_aclk      (axi_aclk),
      .axi_areset    (axi_areset),
      .sw_rst        (sw_rst),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tstrb  (s_axis_tstrb),
      .s_axis_tuser  (s_axis_tuser),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .fifo_rd_en    (fifo_rd_en),
      .fifo_dout     (fifo_dout),
      .fifo_dout_strb(fifo_dout_strb),
      .fifo_empty    (fifo_empty),
      .pkt_count     (pkt_count),
      .proto_err     (proto_err)
   );

   always #5 axi_aclk = ~axi_aclk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Beat whose word k holds base + k
   function automatic logic [DW-1:0] ramp_beat(input logic [31:0] base);
      logic [WORDS-1:0][FW-1:0] r;
      for (int k = 0; k < WORDS; k++) r[IW'(k)] = base + 32'(k);
      return r;
   endfunction

   task automatic push_hdr(input logic [UW-1:0] u);
      logic [WORDS-1:0][FW-1:0] xw;
      xw = DW'(u);
      for (int k = 0; k < WORDS; k++) exp_q.push_back('{d: xw[IW'(k)], s: '1});
   endtask

   task automatic push_beat(input logic [DW-1:0] d, input logic [SW-1:0] s);
      logic [WORDS-1:0][FW-1:0]  dw;
      logic [WORDS-1:0][FSW-1:0] sw;
      dw = d;
      sw = s;
      for (int k = 0; k < WORDS; k++) exp_q.push_back('{d: dw[IW'(k)], s: sw[IW'(k)]});
   endtask

   task automatic push_term();
      for (int k = 0; k < WORDS; k++) exp_q.push_back('{d: '0, s: '0});
   endtask

   // Offer one beat and hold it until the slave takes it
   task automatic send_beat(input logic [DW-1:0] d, input logic [SW-1:0] s,
                            input logic l, input logic [UW-1:0] u);
      int w;
      w = 0;
      @(negedge axi_aclk);
      s_axis_tdata  = d;
      s_axis_tstrb  = s;
      s_axis_tlast  = l;
      s_axis_tuser  = u;
      s_axis_tvalid = 1'b1;
      while (!s_axis_tready && w < 300) begin
         @(negedge axi_aclk);
         w++;
      end
      if (!s_axis_tready) begin
         check("send_timeout", 64'd1, 64'd0);
      end else begin
         @(negedge axi_aclk);
      end
      s_axis_tvalid = 1'b0;
   endtask

   // Read n words, comparing each against the expected queue
   task automatic drain(input int n, input bit toggle);
      word_t e;
      int    w;
      for (int i = 0; i < n; i++) begin
         w = 0;
         while (fifo_empty && w < 300) begin
            fifo_rd_en = 1'b0;
            @(negedge axi_aclk);
            w++;
         end
         if (fifo_empty) begin
            check("drain_timeout", 64'd1, 64'd0);
            fifo_rd_en = 1'b0;
            return;
         end
         if (exp_q.size() == 0) begin
            check("exp_underflow", 64'd1, 64'd0);
            fifo_rd_en = 1'b0;
            return;
         end
         e = exp_q.pop_front();
         check($sformatf("tready_busy%0d", i), 64'(s_axis_tready), 64'd0);
         check($sformatf("word%0d_data", i), 64'(fifo_dout), 64'(e.d));
         check($sformatf("word%0d_strb", i), 64'(fifo_dout_strb), 64'(e.s));
         if (toggle) begin
            fifo_rd_en = 1'b0;
            @(negedge axi_aclk);
            check($sformatf("hold%0d_data", i), 64'(fifo_dout), 64'(e.d));
            check($sformatf("hold%0d_strb", i), 64'(fifo_dout_strb), 64'(e.s));
         end
         fifo_rd_en = 1'b1;
         @(negedge axi_aclk);
      end
      fifo_rd_en = 1'b0;
   endtask

   logic [DW-1:0] b1, b2;
   logic [DW-1:0] rep;
   logic [WORDS-1:0][FW-1:0] repw;

   initial begin
      axi_areset    = 1'b1;
      sw_rst        = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tstrb  = '0;
      s_axis_tuser  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      fifo_rd_en    = 1'b0;

      // Reset values
      repeat (3) @(negedge axi_aclk);
      check("rst_empty", 64'(fifo_empty), 64'd1);
      check("rst_dout", 64'(fifo_dout), 64'd0);
      check("rst_strb", 64'(fifo_dout_strb), 64'd0);
      check("rst_pkt", 64'(pkt_count), 64'd0);
      check("rst_perr", 64'(proto_err), 64'd0);
      check("rst_tready", 64'(s_axis_tready), 64'd0);
      axi_areset = 1'b0;
      @(negedge axi_aclk);

      // Single short packet: half-strobed final beat, no terminator
      for (int k = 0; k < WORDS; k++) repw[IW'(k)] = 32'h1111_1111 * 32'(k + 1);
      rep = repw;
      exp_q.delete();
      for (int k = 0; k < WORDS; k++)
         exp_q.push_back('{d: (k == 0) ? 32'h0000_0042 : 32'h0, s: 4'hF});
      for (int k = 0; k < WORDS; k++)
         exp_q.push_back('{d: 32'h1111_1111 * 32'(k + 1), s: (k < 4) ? 4'hF : 4'h0});
      send_beat(rep, 32'h0000_FFFF, 1'b1, 128'h42);
      drain(16, 1'b0);
      check("t1_empty", 64'(fifo_empty), 64'd1);
      check("t1_pkt", 64'(pkt_count), 64'd1);
      check("t1_perr", 64'(proto_err), 64'd0);

      // Full final beat: terminator beat appended
      b1 = ramp_beat(32'hA000_0000);
      b2 = ramp_beat(32'hB000_0000);
      exp_q.delete();
      push_hdr(128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C);
      push_beat(b1, '1);
      push_beat(b2, '1);
      push_term();
      fork
         begin
            send_beat(b1, '1, 1'b0, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C);
            send_beat(b2, '1, 1'b1, 128'h0);
         end
         drain(32, 1'b0);
      join
      check("t2_empty", 64'(fifo_empty), 64'd1);
      check("t2_pkt", 64'(pkt_count), 64'd2);

      // Output backpressure: each word held across a non-reading cycle
      b1 = ramp_beat(32'hC000_0010);
      exp_q.delete();
      push_hdr(128'h0000_0007_0000_0006_0000_0005_0000_0004);
      push_beat(b1, 32'h000F_FFFF);
      send_beat(b1, 32'h000F_FFFF, 1'b1, 128'h0000_0007_0000_0006_0000_0005_0000_0004);
      drain(16, 1'b1);
      check("t3_pkt", 64'(pkt_count), 64'd3);

      // Upstream gap in S_NEXT
      b1 = ramp_beat(32'hD000_0000);
      b2 = ramp_beat(32'hE000_0000);
      exp_q.delete();
      push_hdr(128'h55);
      push_beat(b1, '1);
      send_beat(b1, '1, 1'b0, 128'h55);
      drain(16, 1'b0);
      for (int g = 0; g < 5; g++) begin
         check($sformatf("gap%0d_empty", g), 64'(fifo_empty), 64'd1);
         check($sformatf("gap%0d_tready", g), 64'(s_axis_tready), 64'd1);
         @(negedge axi_aclk);
      end
      check("gap_pkt", 64'(pkt_count), 64'd3);
      push_beat(b2, 32'h00FF_FFFF);
      send_beat(b2, 32'h00FF_FFFF, 1'b1, 128'h0);
      drain(8, 1'b0);
      check("t4_pkt", 64'(pkt_count), 64'd4);
      check("t4_perr", 64'(proto_err), 64'd0);

      // Reset mid-packet at data idx 3
      b1 = ramp_beat(32'h7700_0000);
      exp_q.delete();
      push_hdr(128'h99);
      push_beat(b1, '1);
      send_beat(b1, '1, 1'b1, 128'h99);
      drain(WORDS + 3, 1'b0);
      check("pre_rst_dout", 64'(fifo_dout), 64'h7700_0003);
      #2 axi_areset = 1'b1;
      #1;
      check("mid_rst_empty", 64'(fifo_empty), 64'd1);
      check("mid_rst_pkt", 64'(pkt_count), 64'd0);
      check("mid_rst_dout", 64'(fifo_dout), 64'd0);
      check("mid_rst_tready", 64'(s_axis_tready), 64'd0);
      @(negedge axi_aclk);
      @(negedge axi_aclk);
      axi_areset = 1'b0;
      b1 = ramp_beat(32'h3300_0000);
      exp_q.delete();
      push_hdr(128'h1234_5678);
      push_beat(b1, 32'h0000_00FF);
      send_beat(b1, 32'h0000_00FF, 1'b1, 128'h1234_5678);
      drain(16, 1'b0);
      check("t6_pkt", 64'(pkt_count), 64'd1);

      // Protocol error: partial non-last beat still forwarded, sticky flag
      b1 = ramp_beat(32'h4400_0000);
      b2 = ramp_beat(32'h6600_0000);
      exp_q.delete();
      push_hdr(128'hAB);
      push_beat(b1, 32'h0000_000F);
      push_beat(b2, '1);
      push_term();
      check("perr_before", 64'(proto_err), 64'd0);
      send_beat(b1, 32'h0000_000F, 1'b0, 128'hAB);
      check("perr_rise", 64'(proto_err), 64'd1);
      drain(16, 1'b0);
      send_beat(b2, '1, 1'b1, 128'h0);
      drain(16, 1'b0);
      check("perr_sticky", 64'(proto_err), 64'd1);
      check("t5_pkt", 64'(pkt_count), 64'd2);
      @(negedge axi_aclk);
      sw_rst = 1'b1;
      @(negedge axi_aclk);
      sw_rst = 1'b0;
      check("swrst_perr", 64'(proto_err), 64'd0);
      check("swrst_pkt", 64'(pkt_count), 64'd0);
      check("swrst_empty", 64'(fifo_empty), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
